// File: rtl/wb_clint_pkg.sv
// Shared CLINT register offsets, register selector type and byte-lane merge helper.
package wb_clint_pkg;

    localparam logic [15:0] CLINT_MSIP_OFF        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO_OFF = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI_OFF = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO_OFF    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI_OFF    = 16'hBFFC;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_MTIME_LO,
        REG_MTIME_HI
    } clint_reg_e;

    // Only the word index is compared; byte offset bits never reach here.
    function automatic clint_reg_e decode_word(input logic [13:0] word);
        clint_reg_e r;
        r = REG_NONE;
        if (word == CLINT_MSIP_OFF[15:2])        r = REG_MSIP;
        if (word == CLINT_MTIMECMP_LO_OFF[15:2]) r = REG_CMP_LO;
        if (word == CLINT_MTIMECMP_HI_OFF[15:2]) r = REG_CMP_HI;
        if (word == CLINT_MTIME_LO_OFF[15:2])    r = REG_MTIME_LO;
        if (word == CLINT_MTIME_HI_OFF[15:2])    r = REG_MTIME_HI;
        return r;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  sel);
        logic [31:0] m;
        m = old_w;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) m[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_clint_timer.sv
// CLINT timer: prescaler, 64-bit mtime with per-word write ports, registered mtip compare.
module clint_timer
    import wb_clint_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    input  logic [63:0] mtimecmp_i,
    output logic [63:0] mtime_o,
    output logic        mtip_o
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      mtime_q, mtime_d;
    logic             mtip_q, mtip_d;
    logic             tick;

    assign tick = (cnt_q == CNT_W'(PRESCALE - 1));

    always_comb begin
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        // A software write replaces the increment; the other word keeps its old value.
        if (wr_lo_i || wr_hi_i) begin
            cnt_d   = '0;
            mtime_d = mtime_q;
            if (wr_lo_i) mtime_d[31:0]  = wdata_i;
            if (wr_hi_i) mtime_d[63:32] = wdata_i;
        end
        mtip_d = (mtime_q >= mtimecmp_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            mtime_q <= '0;
            mtip_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            mtime_q <= mtime_d;
            mtip_q  <= mtip_d;
        end
    end

    assign mtime_o = mtime_q;
    assign mtip_o  = mtip_q;

endmodule

// File: rtl/wb_clint.sv
// Wishbone classic CLINT responder (msip, mtimecmp, mtime) for a single hart.
// Optional WB_CLINT_MTIME_LATCH_EN: low-word mtime read latches the high word for tear-free reads.
module wb_clint
    import wb_clint_pkg::*;
#(
    parameter int          PRESCALE       = 1,
    parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_addr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        mtip_o,
    output logic        msip_o
);

    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] dat_q, dat_d;
    logic        msip_q, msip_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [63:0] mtime;
    logic        req, mapped, wr;
    logic        wr_mtime_lo, wr_mtime_hi;
    logic [31:0] mtime_wdata;
    logic [31:0] rd_word;
    clint_reg_e  reg_sel;
    logic        unused_addr;

    assign unused_addr = ^{wbs_addr_i[31:16], wbs_addr_i[1:0]};

`ifdef WB_CLINT_MTIME_LATCH_EN
    logic [31:0] shadow_q, shadow_d;
`endif

    // One response per request; a held strobe sees its own ack/err and idles a cycle.
    assign req     = wbs_cyc_i && wbs_stb_i && !ack_q && !err_q;
    assign reg_sel = decode_word(wbs_addr_i[15:2]);
    assign mapped  = (reg_sel != REG_NONE);
    assign wr      = req && mapped && wbs_we_i && (wbs_sel_i != 4'b0000);

    assign wr_mtime_lo = wr && (reg_sel == REG_MTIME_LO);
    assign wr_mtime_hi = wr && (reg_sel == REG_MTIME_HI);
    assign mtime_wdata = byte_merge((reg_sel == REG_MTIME_HI) ? mtime[63:32] : mtime[31:0],
                                    wbs_dat_i, wbs_sel_i);

    always_comb begin
        rd_word = 32'd0;
        case (reg_sel)
            REG_MSIP:     rd_word = {31'd0, msip_q};
            REG_CMP_LO:   rd_word = mtimecmp_q[31:0];
            REG_CMP_HI:   rd_word = mtimecmp_q[63:32];
            REG_MTIME_LO: rd_word = mtime[31:0];
`ifdef WB_CLINT_MTIME_LATCH_EN
            REG_MTIME_HI: rd_word = shadow_q;
`else
            REG_MTIME_HI: rd_word = mtime[63:32];
`endif
            default:      rd_word = 32'd0;
        endcase
    end

    always_comb begin
        ack_d      = req && mapped;
        err_d      = req && !mapped;
        dat_d      = (req && mapped && !wbs_we_i) ? rd_word : 32'd0;
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        if (wr && reg_sel == REG_MSIP && wbs_sel_i[0]) msip_d = wbs_dat_i[0];
        if (wr && reg_sel == REG_CMP_LO)
            mtimecmp_d[31:0] = byte_merge(mtimecmp_q[31:0], wbs_dat_i, wbs_sel_i);
        if (wr && reg_sel == REG_CMP_HI)
            mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], wbs_dat_i, wbs_sel_i);
    end

`ifdef WB_CLINT_MTIME_LATCH_EN
    always_comb begin
        shadow_d = shadow_q;
        if (req && !wbs_we_i && reg_sel == REG_MTIME_LO) shadow_d = mtime[63:32];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) shadow_q <= 32'd0;
        else       shadow_q <= shadow_d;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_q      <= 32'd0;
            msip_q     <= 1'b0;
            mtimecmp_q <= MTIMECMP_RESET;
        end else begin
            ack_q      <= ack_d;
            err_q      <= err_d;
            dat_q      <= dat_d;
            msip_q     <= msip_d;
            mtimecmp_q <= mtimecmp_d;
        end
    end

    clint_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_lo_i    (wr_mtime_lo),
        .wr_hi_i    (wr_mtime_hi),
        .wdata_i    (mtime_wdata),
        .mtimecmp_i (mtimecmp_q),
        .mtime_o    (mtime),
        .mtip_o     (mtip_o)
    );

    assign wbs_dat_o = dat_q;
    assign wbs_ack_o = ack_q;
    assign wbs_err_o = err_q;
    assign msip_o    = msip_q;

endmodule

// File: tb/tb_wb_clint.sv
// Bench for wb_clint: two instances (PRESCALE 1 and 4) on one bus, checked every cycle against a reference model.
module tb_wb_clint;

    localparam int PRE [2] = '{1, 4};

    logic        clk = 1'b0;
    logic        rst, cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] addr, wdat;
    logic [31:0] dat0, dat1;
    logic        ack0, ack1, err0, err1, mtip0, mtip1, msip0, msip1;

    int n_total = 0;
    int n_pass  = 0;

    // Reference state, kept in spec terms: whole 64-bit counters and a cycle phase.
    logic        m_ack, m_err, m_msip;
    logic [63:0] m_cmp;
    logic [63:0] m_time [2];
    int          m_pre  [2];
    logic [31:0] m_shadow [2];
    logic        m_mtip [2];
    logic [31:0] m_dat  [2];

    always #5 clk = ~clk;

    wb_clint #(.PRESCALE(1)) dut0 (
        .clk_i(clk), .rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_addr_i(addr), .wbs_dat_i(wdat), .wbs_dat_o(dat0),
        .wbs_ack_o(ack0), .wbs_err_o(err0), .mtip_o(mtip0), .msip_o(msip0));

    wb_clint #(.PRESCALE(4)) dut1 (
        .clk_i(clk), .rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_addr_i(addr), .wbs_dat_i(wdat), .wbs_dat_o(dat1),
        .wbs_ack_o(ack1), .wbs_err_o(err1), .mtip_o(mtip1), .msip_o(msip1));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    // Advance one clock: predict from the inputs now on the bus, then compare both instances.
    task automatic cycle();
        logic        req, mapped, wr;
        logic [15:0] off;
        logic [31:0] w;
        if (rst) begin
            m_ack = 1'b0; m_err = 1'b0; m_msip = 1'b0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
            for (int i = 0; i < 2; i++) begin
                m_time[i] = 64'd0; m_pre[i] = 0; m_shadow[i] = 32'd0;
                m_mtip[i] = 1'b0; m_dat[i] = 32'd0;
            end
        end else begin
            off    = addr[15:0] & 16'hFFFC;
            mapped = off inside {16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC};
            req    = cyc && stb && !m_ack && !m_err;
            wr     = req && mapped && we && (sel != 4'd0);
            for (int i = 0; i < 2; i++) begin
                m_mtip[i] = (m_time[i] >= m_cmp);
                m_dat[i]  = 32'd0;
                if (req && mapped && !we) begin
                    case (off)
                        16'h0000: m_dat[i] = {31'd0, m_msip};
                        16'h4000: m_dat[i] = m_cmp[31:0];
                        16'h4004: m_dat[i] = m_cmp[63:32];
                        16'hBFF8: m_dat[i] = m_time[i][31:0];
`ifdef WB_CLINT_MTIME_LATCH_EN
                        16'hBFFC: m_dat[i] = m_shadow[i];
`else
                        16'hBFFC: m_dat[i] = m_time[i][63:32];
`endif
                        default:  m_dat[i] = 32'd0;
                    endcase
                    if (off == 16'hBFF8) m_shadow[i] = m_time[i][63:32];
                end
                if (wr && off == 16'hBFF8) begin
                    w = m_time[i][31:0];
                    m_time[i][31:0] = merge(w, wdat, sel);
                    m_pre[i] = 0;
                end else if (wr && off == 16'hBFFC) begin
                    w = m_time[i][63:32];
                    m_time[i][63:32] = merge(w, wdat, sel);
                    m_pre[i] = 0;
                end else begin
                    m_pre[i] = (m_pre[i] + 1) % PRE[i];
                    if (m_pre[i] == 0) m_time[i] = m_time[i] + 64'd1;
                end
            end
            if (wr && off == 16'h0000 && sel[0]) m_msip = wdat[0];
            if (wr && off == 16'h4000) begin
                w = m_cmp[31:0];  m_cmp[31:0]  = merge(w, wdat, sel);
            end
            if (wr && off == 16'h4004) begin
                w = m_cmp[63:32]; m_cmp[63:32] = merge(w, wdat, sel);
            end
            m_ack = req && mapped;
            m_err = req && !mapped;
        end
        @(posedge clk);
        #1;
        chk("ack0",  64'(ack0),  64'(m_ack));
        chk("ack1",  64'(ack1),  64'(m_ack));
        chk("err0",  64'(err0),  64'(m_err));
        chk("err1",  64'(err1),  64'(m_err));
        chk("dat0",  64'(dat0),  64'(m_dat[0]));
        chk("dat1",  64'(dat1),  64'(m_dat[1]));
        chk("mtip0", 64'(mtip0), 64'(m_mtip[0]));
        chk("mtip1", 64'(mtip1), 64'(m_mtip[1]));
        chk("msip0", 64'(msip0), 64'(m_msip));
        chk("msip1", 64'(msip1), 64'(m_msip));
    endtask

    task automatic idle(input int n);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    // Single access: request cycle, then an idle cycle. Returns what instance 0 showed on the response.
    task automatic access(input logic w_en, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd, output logic rerr);
        cyc = 1'b1; stb = 1'b1; we = w_en; addr = a; wdat = d; sel = s;
        cycle();
        rd = dat0; rerr = err0;
        idle(1);
    endtask

    initial begin
        logic [31:0] rd, rd_a, rd_b, r;
        logic        e;
        logic [15:0] offs [7];
        offs = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC, 16'h0100, 16'hBFF4};
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'hF; addr = 32'd0; wdat = 32'd0;
        cycle(); cycle();
        chk("rst_dat", 64'(dat0), 64'd0);
        rst = 1'b0;

        // Free-running mtime from reset, mtimecmp all-ones
        access(1'b0, 32'h0200_BFF8, 32'd0, 4'hF, rd_a, e);
        chk("mtime_first", 64'(rd_a), 64'd0);
        access(1'b0, 32'h0200_BFF8, 32'd0, 4'hF, rd_b, e);
        chk("mtime_step", 64'(rd_b - rd_a), 64'd2);
        idle(5);

        // mtimecmp threshold at 0x20
        access(1'b1, 32'h0200_4004, 32'd0,  4'hF, rd, e);
        access(1'b1, 32'h0200_4000, 32'h20, 4'hF, rd, e);
        idle(140);
        chk("mtip_set", 64'(mtip0), 64'd1);
        access(1'b1, 32'h0200_4004, 32'd1, 4'hF, rd, e);
        idle(1);
        chk("mtip_clr", 64'(mtip0), 64'd0);

        // msip
        access(1'b1, 32'h0200_0000, 32'h1, 4'hF, rd, e);
        chk("msip_set", 64'(msip0), 64'd1);
        access(1'b0, 32'h0200_0000, 32'd0, 4'hF, rd, e);
        chk("msip_rd1", 64'(rd), 64'h1);
        access(1'b1, 32'h0200_0000, 32'h0, 4'hF, rd, e);
        access(1'b0, 32'h0200_0000, 32'd0, 4'hF, rd, e);
        chk("msip_rd0", 64'(rd), 64'h0);
        access(1'b1, 32'h0200_0000, 32'hFFFF_FFFF, 4'hF, rd, e);
        access(1'b0, 32'h0200_0000, 32'd0, 4'hF, rd, e);
        chk("msip_rdf", 64'(rd), 64'h1);
        access(1'b1, 32'h0200_0000, 32'h0, 4'h0, rd, e);
        chk("msip_sel0", 64'(msip0), 64'd1);

        // Low-word carry into high word, then full 64-bit wrap
        access(1'b1, 32'h0200_BFFC, 32'd0, 4'hF, rd, e);
        access(1'b1, 32'h0200_BFF8, 32'hFFFF_FFFF, 4'hF, rd, e);
        idle(4);
        access(1'b1, 32'h0200_BFFC, 32'hFFFF_FFFF, 4'hF, rd, e);
        access(1'b1, 32'h0200_BFF8, 32'hFFFF_FFFE, 4'hF, rd, e);
        idle(8);
        access(1'b0, 32'h0200_BFFC, 32'd0, 4'hF, rd, e);

        // Unmapped offsets and a held strobe
        access(1'b1, 32'h0200_0100, 32'h1234, 4'hF, rd, e);
        chk("err_0100", 64'(e), 64'd1);
        access(1'b0, 32'h0200_BFF4, 32'd0, 4'hF, rd, e);
        chk("err_bff4", 64'(e), 64'd1);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h0200_0100;
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("held_err", 64'(err0), 64'((k % 2) == 0));
        end
        idle(1);

        // Tear-free read: lo read at 0x0_FFFFFFFE, hi read after the low word wrapped
        access(1'b1, 32'h0200_BFFC, 32'd0, 4'hF, rd, e);
        access(1'b1, 32'h0200_BFF8, 32'hFFFF_FFFD, 4'hF, rd, e);
        access(1'b0, 32'h0200_BFF8, 32'd0, 4'hF, rd, e);
        chk("latch_lo", 64'(rd), 64'hFFFF_FFFE);
        access(1'b0, 32'h0200_BFFC, 32'd0, 4'hF, rd, e);
`ifdef WB_CLINT_MTIME_LATCH_EN
        chk("latch_hi", 64'(rd), 64'd0);
`else
        chk("latch_hi", 64'(rd), 64'd1);
`endif

        // Reset in the middle of a request
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h0200_0000; wdat = 32'h1; sel = 4'hF;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        idle(1);
        chk("rst_mid_msip", 64'(msip0), 64'd0);

        // Randomized traffic
        for (int t = 0; t < 400; t++) begin
            r = $urandom;
            if ($urandom_range(0, 7) == 7) addr = $urandom;
            else addr = {r[31:16], offs[$urandom_range(0, 6)] & 16'hFFFC} | {30'd0, r[1:0]};
            we   = ($urandom_range(0, 1) == 1);
            sel  = 4'($urandom_range(0, 15));
            wdat = $urandom;
            cyc  = 1'b1; stb = 1'b1;
            rst  = ($urandom_range(0, 50) == 0);
            for (int h = $urandom_range(1, 3); h > 0; h--) begin
                cycle();
                rst = 1'b0;
            end
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                cyc = 1'b0; stb = ($urandom_range(0, 1) == 1);
                cycle();
            end
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
